// File: rtl/acog_alu_pkg.sv
// Shared definitions for the cog ALU add/sub pipeline: opcode encoding,
// flag-kind classification and elaboration-time parameter checks.
package acog_alu_pkg;

  localparam int OPCODE_W = 4;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_ADD    = 4'd0;
  localparam opcode_t OP_SUB    = 4'd1;
  localparam opcode_t OP_ADDABS = 4'd2;
  localparam opcode_t OP_SUBABS = 4'd3;
  localparam opcode_t OP_SUMC   = 4'd4;
  localparam opcode_t OP_SUMNC  = 4'd5;
  localparam opcode_t OP_SUMZ   = 4'd6;
  localparam opcode_t OP_SUMNZ  = 4'd7;
  localparam opcode_t OP_ADDX   = 4'd8;
  localparam opcode_t OP_SUBX   = 4'd9;
  localparam opcode_t OP_ADDSX  = 4'd10;
  localparam opcode_t OP_SUBSX  = 4'd11;

  // What the new C flag means for a given opcode.
  typedef enum logic [1:0] {
    FK_CARRY,   // unsigned carry out of the adder
    FK_BORROW,  // unsigned borrow, i.e. inverted carry
    FK_OVF,     // signed overflow
    FK_PASS     // reserved opcode: flags pass through
  } flag_kind_t;

  function automatic flag_kind_t flag_kind(opcode_t op);
    flag_kind_t kind;
    case (op)
      OP_ADD, OP_ADDABS, OP_ADDX:                  kind = FK_CARRY;
      OP_SUB, OP_SUBABS, OP_SUBX:                  kind = FK_BORROW;
      OP_SUMC, OP_SUMNC, OP_SUMZ, OP_SUMNZ,
      OP_ADDSX, OP_SUBSX:                          kind = FK_OVF;
      default:                                     kind = FK_PASS;
    endcase
    return kind;
  endfunction

  // Only one- and two-stage pipelines are implemented.
  function automatic bit stages_ok(int stages);
    return (stages == 1) || (stages == 2);
  endfunction

endpackage

// File: rtl/acog_addsub_core.sv
// Combinational datapath of the add/sub unit, split into two halves so the
// top level can place a register between them:
//   select half: picks the adder addend (S, -S, |S|, ~S), carry-in and the
//                sign of the effective addend used for overflow detection;
//   adder half : one W+1-bit adder plus C/Z/illegal flag generation.
module acog_addsub_core
  import acog_alu_pkg::*;
#(
  parameter int W = 32
) (
  // select half
  input  opcode_t        sel_opcode,
  input  logic [W-1:0]   sel_s,
  input  logic           sel_flag_c,
  input  logic           sel_flag_z,
  output logic [W-1:0]   sel_addend,
  output logic           sel_cin,
  output logic           sel_eff_msb,
  // adder half
  input  opcode_t        add_opcode,
  input  logic [W-1:0]   add_d,
  input  logic [W-1:0]   add_addend,
  input  logic           add_cin,
  input  logic           add_eff_msb,
  input  logic           add_flag_c,
  input  logic           add_flag_z,
  output logic [W-1:0]   q,
  output logic           flag_c,
  output logic           flag_z,
  output logic           illegal
);

  logic [W-1:0] neg_s;
  logic [W-1:0] abs_s;
  logic         sum_sub;

  // -S wraps mod 2^W, so |most-negative| is the most-negative value itself.
  assign neg_s = (~sel_s) + {{(W-1){1'b0}}, 1'b1};
  assign abs_s = sel_s[W-1] ? neg_s : sel_s;

  // SUM* ops subtract when their condition flag selects the D-S form.
  assign sum_sub = ((sel_opcode == OP_SUMC)  &  sel_flag_c) |
                   ((sel_opcode == OP_SUMNC) & ~sel_flag_c) |
                   ((sel_opcode == OP_SUMZ)  &  sel_flag_z) |
                   ((sel_opcode == OP_SUMNZ) & ~sel_flag_z);

  // Addend / carry-in selection; subtraction is D + ~S + 1 (or + ~C).
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    sel_addend  = sel_s;
    sel_cin     = 1'b0;
    sel_eff_msb = sel_s[W-1];
    case (sel_opcode)
      OP_ADD: ;
      OP_SUB, OP_SUBABS: begin
        sel_addend  = (sel_opcode == OP_SUB) ? ~sel_s : ~abs_s;
        sel_cin     = 1'b1;
        sel_eff_msb = 1'b0;
      end
      OP_ADDABS: begin
        sel_addend  = abs_s;
        sel_eff_msb = abs_s[W-1];
      end
      OP_SUMC, OP_SUMNC, OP_SUMZ, OP_SUMNZ: begin
        if (sum_sub) begin
          sel_addend  = ~sel_s;
          sel_cin     = 1'b1;
          sel_eff_msb = neg_s[W-1];
        end
      end
      OP_ADDX, OP_ADDSX: begin
        sel_cin = sel_flag_c;
      end
      OP_SUBX, OP_SUBSX: begin
        sel_addend  = ~sel_s;
        sel_cin     = ~sel_flag_c;
        sel_eff_msb = ~sel_s[W-1];
      end
      default: begin
        sel_addend  = '0;
        sel_eff_msb = 1'b0;
      end
    endcase
  end

  logic [W:0]   sum;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  flag_kind_t   kind;

  assign sum    = {1'b0, add_d} + {1'b0, add_addend} + {{W{1'b0}}, add_cin};
  assign result = sum[W-1:0];
  assign carry  = sum[W];
  // Overflow: D has the sign of the effective addend and the result does not.
  assign ovf    = (add_d[W-1] == add_eff_msb) & (result[W-1] != add_d[W-1]);
  assign kind   = flag_kind(add_opcode);

  // Result and flag generation; extended ops chain Z across words.
  always_comb begin
    q       = result;
    flag_c  = carry;
    flag_z  = ~|result;
    illegal = 1'b0;
    if (add_opcode >= OP_ADDX) flag_z = add_flag_z & ~|result;
    case (kind)
      FK_CARRY:  flag_c = carry;
      FK_BORROW: flag_c = ~carry;
      FK_OVF:    flag_c = ovf;
      default: begin
        q       = add_d;
        flag_c  = add_flag_c;
        flag_z  = add_flag_z;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/acog_sum_pipe.sv
// Pipelined add/sub unit for the cog ALU. Operands enter through a
// valid/ready handshake, results leave through another; an opaque tag rides
// along so writeback can route each result. STAGES=2 registers the selected
// addend before the adder, STAGES=1 does everything in a single stage.
module acog_sum_pipe
  import acog_alu_pkg::*;
#(
  parameter int W      = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 9
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_o,
  input  opcode_t          opcode_in,
  input  logic [W-1:0]     d_in,
  input  logic [W-1:0]     s_in,
  input  logic             flag_c_in,
  input  logic             flag_z_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid_o,
  input  logic             out_ready_in,
  output logic [W-1:0]     q_o,
  output logic             flag_c_o,
  output logic             flag_z_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("acog_sum_pipe: STAGES must be 1 or 2");
  end
  if (W < 8) begin : g_bad_width
    $error("acog_sum_pipe: W must be at least 8");
  end

  // Inputs of the adder half, either straight from the ports or from stage 1.
  opcode_t          a_opcode;
  logic [W-1:0]     a_d;
  logic [W-1:0]     a_addend;
  logic             a_cin;
  logic             a_eff_msb;
  logic             a_flag_c;
  logic             a_flag_z;
  logic [TAG_W-1:0] a_tag;
  logic             a_valid;

  logic [W-1:0]     sel_addend;
  logic             sel_cin;
  logic             sel_eff_msb;
  logic [W-1:0]     core_q;
  logic             core_c;
  logic             core_z;
  logic             core_ill;

  // Output register loads when empty or when its result leaves this cycle.
  logic out_load;
  assign out_load = ~out_valid_o | out_ready_in;

  acog_addsub_core #(.W(W)) u_core (
    .sel_opcode  (opcode_in),
    .sel_s       (s_in),
    .sel_flag_c  (flag_c_in),
    .sel_flag_z  (flag_z_in),
    .sel_addend  (sel_addend),
    .sel_cin     (sel_cin),
    .sel_eff_msb (sel_eff_msb),
    .add_opcode  (a_opcode),
    .add_d       (a_d),
    .add_addend  (a_addend),
    .add_cin     (a_cin),
    .add_eff_msb (a_eff_msb),
    .add_flag_c  (a_flag_c),
    .add_flag_z  (a_flag_z),
    .q           (core_q),
    .flag_c      (core_c),
    .flag_z      (core_z),
    .illegal     (core_ill)
  );

  if (STAGES == 2) begin : g_two_stage
    logic             s1_valid;
    opcode_t          s1_opcode;
    logic [W-1:0]     s1_d;
    logic [W-1:0]     s1_addend;
    logic             s1_cin;
    logic             s1_eff_msb;
    logic             s1_flag_c;
    logic             s1_flag_z;
    logic [TAG_W-1:0] s1_tag;

    // Stage 1 is free when empty or when its content moves on this cycle.
    assign in_ready_o = ~s1_valid | out_load;

    // Stage 1: capture opcode, D, selected addend and carry-in.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        // NOTE: datapath registers are reset too so nothing reads X after reset.
        s1_valid   <= 1'b0;
        s1_opcode  <= OP_ADD;
        s1_d       <= '0;
        s1_addend  <= '0;
        s1_cin     <= 1'b0;
        s1_eff_msb <= 1'b0;
        s1_flag_c  <= 1'b0;
        s1_flag_z  <= 1'b0;
        s1_tag     <= '0;
      end else begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (in_ready_o) s1_valid <= in_valid_in;
        if (in_valid_in && in_ready_o) begin
          s1_opcode  <= opcode_in;
          s1_d       <= d_in;
          s1_addend  <= sel_addend;
          s1_cin     <= sel_cin;
          s1_eff_msb <= sel_eff_msb;
          s1_flag_c  <= flag_c_in;
          s1_flag_z  <= flag_z_in;
          s1_tag     <= tag_in;
        end
      end
    end

    assign a_valid   = s1_valid;
    assign a_opcode  = s1_opcode;
    assign a_d       = s1_d;
    assign a_addend  = s1_addend;
    assign a_cin     = s1_cin;
    assign a_eff_msb = s1_eff_msb;
    assign a_flag_c  = s1_flag_c;
    assign a_flag_z  = s1_flag_z;
    assign a_tag     = s1_tag;
  end else begin : g_one_stage
    assign in_ready_o = out_load;
    assign a_valid    = in_valid_in;
    assign a_opcode   = opcode_in;
    assign a_d        = d_in;
    assign a_addend   = sel_addend;
    assign a_cin      = sel_cin;
    assign a_eff_msb  = sel_eff_msb;
    assign a_flag_c   = flag_c_in;
    assign a_flag_z   = flag_z_in;
    assign a_tag      = tag_in;
  end

  // Output stage: results are held unchanged while the consumer stalls.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      out_valid_o <= 1'b0;
      q_o         <= '0;
      flag_c_o    <= 1'b0;
      flag_z_o    <= 1'b0;
      tag_o       <= '0;
      illegal_o   <= 1'b0;
    end else if (out_load) begin
      out_valid_o <= a_valid;
      if (a_valid) begin
        q_o       <= core_q;
        flag_c_o  <= core_c;
        flag_z_o  <= core_z;
        tag_o     <= a_tag;
        illegal_o <= core_ill;
      end
    end
  end

endmodule

// File: tb/tb_acog_sum_pipe.sv
// Self-checking bench for acog_sum_pipe (W=32, STAGES=2): directed vector
// table streamed back-to-back, multi-word ADDX/SUBX chains, stall/reset
// corner cases and a throttled random run against a behavioural model.
module tb_acog_sum_pipe;
  import acog_alu_pkg::*;

  localparam int W      = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 9;
  localparam int N_RND  = 3000;

  logic             clk_in = 1'b0;
  logic             reset_n_in = 1'b0;
  logic             in_valid_in;
  logic             in_ready_o;
  logic [3:0]       opcode_in;
  logic [W-1:0]     d_in;
  logic [W-1:0]     s_in;
  logic             flag_c_in;
  logic             flag_z_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid_o;
  logic             out_ready_in;
  logic [W-1:0]     q_o;
  logic             flag_c_o;
  logic             flag_z_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;

  acog_sum_pipe #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .in_valid_in  (in_valid_in),
    .in_ready_o   (in_ready_o),
    .opcode_in    (opcode_in),
    .d_in         (d_in),
    .s_in         (s_in),
    .flag_c_in    (flag_c_in),
    .flag_z_in    (flag_z_in),
    .tag_in       (tag_in),
    .out_valid_o  (out_valid_o),
    .out_ready_in (out_ready_in),
    .q_o          (q_o),
    .flag_c_o     (flag_c_o),
    .flag_z_o     (flag_z_o),
    .tag_o        (tag_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Packed view of one output beat: {valid, tag, illegal, z, c, q}.
  function automatic logic [63:0] res(logic v, logic [31:0] q, logic c, logic z,
                                      logic ill, logic [8:0] tag);
    return {19'h0, v, tag, ill, z, c, q};
  endfunction

  function automatic logic [63:0] dut_res();
    return res(out_valid_o, q_o, flag_c_o, flag_z_o, illegal_o, tag_o);
  endfunction

  // Behavioural reference using wide integer arithmetic.
  function automatic logic [63:0] model(logic [3:0] op, logic [31:0] d, logic [31:0] s,
                                        logic fc, logic fz, logic [8:0] tag);
    longint du = longint'(d);
    longint su = longint'(s);
    longint ds = longint'($signed(d));
    longint ss = longint'($signed(s));
    longint ci = longint'(fc);
    longint smax = 64'sd2147483647;
    longint smin = -64'sd2147483648;
    longint a;
    longint eff;
    longint r;
    logic [31:0] q;
    logic c;
    logic z;
    bit sub;
    a = s[31] ? (64'sd4294967296 - su) : su;
    r = 0;
    c = 1'b0;
    case (op)
      4'd0:  begin r = du + su;      c = (r >>> 32) != 0; end
      4'd1:  begin r = du - su;      c = du < su;         end
      4'd2:  begin r = du + a;       c = (r >>> 32) != 0; end
      4'd3:  begin r = du - a;       c = du < a;          end
      4'd4, 4'd5, 4'd6, 4'd7: begin
        case (op)
          4'd4:    sub = fc;
          4'd5:    sub = !fc;
          4'd6:    sub = fz;
          default: sub = !fz;
        endcase
        eff = sub ? ((s == 32'h8000_0000) ? smin : -ss) : ss;
        r = ds + eff;
        c = (r > smax) || (r < smin);
      end
      4'd8:  begin r = du + su + ci; c = (r >>> 32) != 0; end
      4'd9:  begin r = du - su - ci; c = du < (su + ci);  end
      4'd10: begin r = ds + ss + ci; c = (r > smax) || (r < smin); end
      4'd11: begin r = ds - ss - ci; c = (r > smax) || (r < smin); end
      default: ;
    endcase
    q = r[31:0];
    z = (q == 32'h0) && ((op < 4'd8) || fz);
    if (op >= 4'd12) return res(1'b1, d, fc, fz, 1'b1, tag);
    return res(1'b1, q, c, z, 1'b0, tag);
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d;
    logic [31:0] s;
    logic        fc;
    logic        fz;
    logic [31:0] q;
    logic        c;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic [3:0] op, logic [31:0] d, logic [31:0] s, logic fc,
                               logic fz, logic [31:0] q, logic c, logic z, logic ill);
    vec_t v;
    v.op = op; v.d = d; v.s = s; v.fc = fc; v.fz = fz;
    v.q = q; v.c = c; v.z = z; v.ill = ill;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(logic [3:0] op, logic [31:0] d, logic [31:0] s, logic fc, logic fz,
                       logic [8:0] tag);
    opcode_in = op; d_in = d; s_in = s; flag_c_in = fc; flag_z_in = fz; tag_in = tag;
  endtask

  // Waits (bounded) for a result beat; leaves time at the negedge it appeared.
  task automatic wait_out(string name);
    int n = 0;
    @(negedge clk_in);
    while (!out_valid_o && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    check({name, "_seen"}, 64'(out_valid_o), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       lo_c;
    logic       lo_z;
    logic [8:0] tg;
    logic       acc;
    int         sent;
    int         recv;
    logic [63:0] exp_q[$];

    in_valid_in = 1'b0;
    out_ready_in = 1'b1;
    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 9'h0);

    // Directed vectors: op, D, S, C, Z -> q, C, Z, illegal
    vecs.push_back(mkv(OP_ADD,    32'hFFFFFFFD, 32'h00000004, 0, 0, 32'h00000001, 1, 0, 0));
    vecs.push_back(mkv(OP_SUB,    32'h00000003, 32'h00000004, 0, 0, 32'hFFFFFFFF, 1, 0, 0));
    vecs.push_back(mkv(OP_SUB,    32'h00000005, 32'h00000005, 1, 0, 32'h00000000, 0, 1, 0));
    vecs.push_back(mkv(OP_ADDABS, 32'hFFFFFFFD, 32'hFFFFFFFD, 0, 0, 32'h00000000, 1, 1, 0));
    vecs.push_back(mkv(OP_SUBABS, 32'h00000003, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFF, 1, 0, 0));
    vecs.push_back(mkv(OP_ADDABS, 32'h00000000, 32'h80000000, 0, 0, 32'h80000000, 0, 0, 0));
    vecs.push_back(mkv(OP_SUBABS, 32'h00000000, 32'h80000000, 0, 0, 32'h80000000, 1, 0, 0));
    vecs.push_back(mkv(OP_SUMC,   32'h80000000, 32'h00000001, 1, 0, 32'h7FFFFFFF, 1, 0, 0));
    vecs.push_back(mkv(OP_SUMC,   32'h00000005, 32'h00000003, 0, 0, 32'h00000008, 0, 0, 0));
    vecs.push_back(mkv(OP_SUMC,   32'hFFFFFFFF, 32'h80000000, 1, 0, 32'h7FFFFFFF, 1, 0, 0));
    vecs.push_back(mkv(OP_SUMNC,  32'h00000005, 32'h00000003, 0, 0, 32'h00000002, 0, 0, 0));
    vecs.push_back(mkv(OP_SUMNC,  32'h7FFFFFFF, 32'h00000001, 1, 0, 32'h80000000, 1, 0, 0));
    vecs.push_back(mkv(OP_SUMZ,   32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 1, 0, 0));
    vecs.push_back(mkv(OP_SUMZ,   32'h00000005, 32'h00000005, 0, 1, 32'h00000000, 0, 1, 0));
    vecs.push_back(mkv(OP_SUMNZ,  32'h00000005, 32'h00000005, 0, 1, 32'h0000000A, 0, 0, 0));
    vecs.push_back(mkv(OP_SUMNZ,  32'h80000000, 32'h00000001, 0, 0, 32'h7FFFFFFF, 1, 0, 0));
    vecs.push_back(mkv(OP_ADDX,   32'hFFFFFFFF, 32'h00000001, 0, 1, 32'h00000000, 1, 1, 0));
    vecs.push_back(mkv(OP_ADDX,   32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 0, 0, 0));
    vecs.push_back(mkv(OP_SUBX,   32'h00000000, 32'h00000000, 1, 0, 32'hFFFFFFFF, 1, 0, 0));
    vecs.push_back(mkv(OP_ADDSX,  32'h7FFFFFFF, 32'h00000000, 1, 1, 32'h80000000, 1, 0, 0));
    vecs.push_back(mkv(OP_SUBSX,  32'h80000000, 32'h00000000, 1, 0, 32'h7FFFFFFF, 1, 0, 0));
    vecs.push_back(mkv(OP_SUBSX,  32'h00000001, 32'h00000000, 1, 1, 32'h00000000, 0, 1, 0));
    vecs.push_back(mkv(4'd13,     32'h12345678, 32'h00000009, 1, 0, 32'h12345678, 1, 0, 1));
    vecs.push_back(mkv(4'd15,     32'h00000000, 32'hFFFFFFFF, 0, 1, 32'h00000000, 0, 1, 1));

    // Reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    #1;
    check("reset_outputs", dut_res(), res(0, 32'h0, 0, 0, 0, 9'h0));
    check("reset_in_ready", 64'(in_ready_o), 64'd1);
    step();

    // Back-to-back stream: each result must appear exactly STAGES cycles later.
    for (int i = 0; i < vecs.size() + STAGES; i++) begin
      if (i < vecs.size()) begin
        tg = 9'(i * 37 + 5);
        drive(vecs[i].op, vecs[i].d, vecs[i].s, vecs[i].fc, vecs[i].fz, tg);
        in_valid_in = 1'b1;
      end else begin
        in_valid_in = 1'b0;
      end
      @(negedge clk_in);
      if (i >= STAGES) begin
        tg = 9'((i - STAGES) * 37 + 5);
        check($sformatf("vec%0d", i - STAGES), dut_res(),
              res(1'b1, vecs[i-STAGES].q, vecs[i-STAGES].c, vecs[i-STAGES].z,
                  vecs[i-STAGES].ill, tg));
      end else begin
        check($sformatf("latency%0d", i), 64'(out_valid_o), 64'd0);
      end
      step();
    end

    // 64-bit ADDX chain: FFFFFFFF_FFFFFFFF + 0_00000001 with Z seeded 1
    drive(OP_ADDX, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 9'h010);
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    wait_out("addx_lo");
    check("addx_lo", dut_res(), res(1, 32'h0, 1, 1, 0, 9'h010));
    lo_c = flag_c_o;
    lo_z = flag_z_o;
    step();
    drive(OP_ADDX, 32'h0, 32'h0, lo_c, lo_z, 9'h011);
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    wait_out("addx_hi");
    check("addx_hi", dut_res(), res(1, 32'h1, 0, 0, 0, 9'h011));
    step();

    // 64-bit SUBX chain: 0 - 1 -> FFFFFFFF_FFFFFFFF
    drive(OP_SUBX, 32'h0, 32'h1, 1'b0, 1'b1, 9'h020);
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    wait_out("subx_lo");
    check("subx_lo", dut_res(), res(1, 32'hFFFFFFFF, 1, 0, 0, 9'h020));
    lo_c = flag_c_o;
    lo_z = flag_z_o;
    step();
    drive(OP_SUBX, 32'h0, 32'h0, lo_c, lo_z, 9'h021);
    in_valid_in = 1'b1;
    step();
    in_valid_in = 1'b0;
    wait_out("subx_hi");
    check("subx_hi", dut_res(), res(1, 32'hFFFFFFFF, 1, 0, 0, 9'h021));
    step();

    // Stall with both stages full, then reset mid-flight.
    out_ready_in = 1'b0;
    drive(OP_ADD, 32'h1, 32'h2, 1'b0, 1'b0, 9'h007);
    in_valid_in = 1'b1;
    step();
    drive(OP_SUB, 32'hA, 32'h3, 1'b0, 1'b0, 9'h008);
    step();
    in_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check($sformatf("stall_hold%0d", k), dut_res(), res(1, 32'h3, 0, 0, 0, 9'h007));
      check($sformatf("stall_ready%0d", k), 64'(in_ready_o), 64'd0);
      step();
    end
    #3;
    reset_n_in = 1'b0;
    #1;
    check("midreset_outputs", dut_res(), res(0, 32'h0, 0, 0, 0, 9'h0));
    check("midreset_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    out_ready_in = 1'b1;
    repeat (3) step();
    @(negedge clk_in);
    check("midreset_dropped", 64'(out_valid_o), 64'd0);
    step();

    // Throttled random traffic against the model.
    sent = 0;
    recv = 0;
    acc = 1'b0;
    in_valid_in = 1'b0;
    for (int cyc = 0; cyc < 40000 && recv < N_RND; cyc++) begin
      if (!in_valid_in || acc) begin
        if (sent < N_RND && $urandom_range(0, 3) != 0) begin
          drive(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 9'(sent));
          in_valid_in = 1'b1;
        end else begin
          in_valid_in = 1'b0;
        end
      end
      out_ready_in = ($urandom_range(0, 2) != 0);
      @(negedge clk_in);
      acc = in_valid_in && in_ready_o;
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious", 64'(out_valid_o), 64'd0);
        end else begin
          check($sformatf("rnd%0d", recv), dut_res(), exp_q[0]);
          if (out_ready_in) begin
            void'(exp_q.pop_front());
            recv++;
          end
        end
      end
      if (acc) begin
        exp_q.push_back(model(opcode_in, d_in, s_in, flag_c_in, flag_z_in, tag_in));
        sent++;
      end
      step();
    end
    in_valid_in = 1'b0;
    check("rnd_received", 64'(recv), 64'(N_RND));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
